// File: rtl/key_event_decoder_pkg.sv
// key_evt_pkg: shared state encodings and default thresholds for key_event_decoder.
package key_evt_pkg;
  localparam int CNT_W_DEF     = 12;
  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;
  localparam int DBL_MS_DEF    = 300;
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    PRESSED   = 5'b00010,
    LONG_HELD = 5'b00100,
    WAIT_DBL  = 5'b01000,
    SECOND    = 5'b10000
  } state_t;
endpackage

// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: debounced key inputs, 1 kHz tick and decoded key pulses.
interface key_event_decoder_if;
  logic TICK;
  logic KEY_FLAG;
  logic KEY_STATE;
  logic SHORT_PULSE;
  logic LONG_PULSE;
  logic REPEAT_PULSE;
  logic DOUBLE_PULSE;
  logic KEY_HELD;
  modport master (
    output TICK, KEY_FLAG, KEY_STATE,
    input  SHORT_PULSE, LONG_PULSE, REPEAT_PULSE, DOUBLE_PULSE, KEY_HELD
  );
  modport slave (
    input  TICK, KEY_FLAG, KEY_STATE,
    output SHORT_PULSE, LONG_PULSE, REPEAT_PULSE, DOUBLE_PULSE, KEY_HELD
  );
endinterface

// File: rtl/key_event_decoder_timer.sv
// evt_timer: tick counter with clear; hit flags the tick that reaches the threshold.
module evt_timer
  import key_evt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             TICK,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic             hit
);
  assign hit = TICK & (count == threshold - 1'b1);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) count <= '0;
    else if (clr) count <= '0;
    else if (TICK) count <= count + 1'b1;
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key edges into short/long/repeat pulses.
// Define KEY_DOUBLE_EN to add double-click detection (WAIT_DBL/SECOND states).
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int DBL_MS    = DBL_MS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic CLK,
  input logic nRST,
  key_event_decoder_if.slave bus
);
  state_t state;
  logic [CNT_W-1:0] count, thr;
  logic hit, clr, press_ev, rel_ev;
  logic short_q, long_q, rep_q, held_q;
`ifdef KEY_DOUBLE_EN
  logic dbl_q;
`endif
  assign press_ev = bus.KEY_FLAG & ~bus.KEY_STATE;
  assign rel_ev   = bus.KEY_FLAG & bus.KEY_STATE;
  assign thr = state == LONG_HELD ? CNT_W'(REPEAT_MS) :
               state == WAIT_DBL  ? CNT_W'(DBL_MS)    : CNT_W'(LONG_MS);
  // Idle holds the counter at zero so every timed state starts from a clean count.
  assign clr = (state == IDLE) | hit | (rel_ev & (state != WAIT_DBL)) |
               (press_ev & (state == WAIT_DBL));
  evt_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr       (clr),
    .TICK      (bus.TICK),
    .threshold (thr),
    .count     (count),
    .hit       (hit)
  );
  count_bound: assert property (@(posedge CLK) disable iff (!nRST) count < thr);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state   <= IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEY_DOUBLE_EN
      dbl_q   <= 1'b0;
`endif
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
`ifdef KEY_DOUBLE_EN
      dbl_q   <= 1'b0;
`endif
      case (state)
        IDLE:
          if (press_ev) begin
            state  <= PRESSED;
            held_q <= 1'b1;
          end
        PRESSED:
          if (rel_ev) begin
            held_q <= 1'b0;
`ifdef KEY_DOUBLE_EN
            state  <= WAIT_DBL;
`else
            state   <= IDLE;
            short_q <= 1'b1;
`endif
          end else if (hit) begin
            state  <= LONG_HELD;
            long_q <= 1'b1;
          end
        LONG_HELD:
          if (rel_ev) begin
            state  <= IDLE;
            held_q <= 1'b0;
          end else if (hit) rep_q <= 1'b1;
`ifdef KEY_DOUBLE_EN
        WAIT_DBL:
          if (press_ev) state <= SECOND;
          else if (hit) begin
            state   <= IDLE;
            short_q <= 1'b1;
          end
        SECOND:
          if (rel_ev) begin
            state <= IDLE;
            dbl_q <= 1'b1;
          end else if (hit) begin
            state  <= LONG_HELD;
            long_q <= 1'b1;
            held_q <= 1'b1;
          end
`endif
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  assign bus.SHORT_PULSE  = short_q;
  assign bus.LONG_PULSE   = long_q;
  assign bus.REPEAT_PULSE = rep_q;
  assign bus.KEY_HELD     = held_q;
`ifdef KEY_DOUBLE_EN
  assign bus.DOUBLE_PULSE = dbl_q;
`else
  assign bus.DOUBLE_PULSE = 1'b0;
`endif
endmodule
